serial_deframer: RTL and testbench
==================================

# serial_deframer

Receive-side stage directly downstream of the asynchronous-reset D flip-flop in the serial input path. Takes the registered serial bit (`q` of the flop) one bit per qualified clock and finds start/stop framing. Checks even parity, deserialises DATA_W bits LSB-first, and presents each good byte on a valid/ready output held in a one-deep buffer.

## Interface
- DATA_W, 8, number of data bits per frame (2..16)
- clk  input  1  rising-edge clock shared with the upstream flop
- reset  input  1  asynchronous, active-low; reset=0 clears all state immediately, release is synchronous to clk
- din  input  1  serial line bit (registered flop output); idle level 1
- din_valid  input  1  din is sampled only on edges where din_valid=1
- dout  output  DATA_W  received data word, stable while dout_valid=1
- dout_valid  output  1  dout holds an unconsumed good frame
- dout_ready  input  1  consumer accepts dout on an edge where dout_valid=1 and dout_ready=1
- parity_err  output  1  one-cycle pulse: frame discarded, parity mismatch
- frame_err  output  1  one-cycle pulse: frame discarded, stop bit = 0
- overflow  output  1  one-cycle pulse: good frame dropped because buffer full

## Operation
- Frame on din, one bit per sampled edge: start (0), DATA_W data bits LSB first, parity bit (even: XOR of data and parity = 0), stop (1).
- FSM states: IDLE, DATA, PARITY, STOP, WAIT_IDLE. State changes only on sampled edges (din_valid=1), except reset.
- IDLE: din=0 -> DATA, bit counter = 0; din=1 -> stay.
- DATA: shift din into bit position counter; counter = DATA_W-1 -> PARITY, else counter+1.
- PARITY: capture parity bit -> STOP.
- STOP, din=1, parity OK: frame good -> IDLE; attempt buffer load.
- STOP, din=1, parity bad: pulse parity_err, discard -> IDLE.
- STOP, din=0: pulse frame_err (takes precedence over parity_err; only frame_err pulses), discard -> WAIT_IDLE.
- WAIT_IDLE: stay until a sampled din=1 -> IDLE. A 0 after a bad stop is never taken as a start.
- Buffer load, good frame:
  - dout_valid=0: load dout, dout_valid=1.
  - dout_valid=1 and dout_ready=1 on the same edge: old word consumed, new word loaded, dout_valid stays 1.
  - dout_valid=1 and dout_ready=0: new frame dropped, old dout kept, overflow pulses.
- Consumption without load: dout_valid=1 and dout_ready=1 -> dout_valid=0. dout keeps its last value.
- din_valid=0 edges: FSM, counter and shift register hold. The output handshake still operates.
- Error and overflow pulses never coincide with each other. A pulse occurs only on the edge that evaluates STOP.

## Timing
- Reset values: state IDLE, counter 0, shift register 0, dout=0, dout_valid=0, parity_err=0, frame_err=0, overflow=0.
- Reset asserted mid-frame: partial frame discarded. After release, the block waits in IDLE for a new start bit.
- Latency: the stop bit is sampled at edge N. dout/dout_valid or the corresponding pulse is visible after edge N. The pulse is high exactly for cycle N..N+1.
- Minimum frame length: DATA_W+3 sampled edges. Back-to-back frames need no idle bits: the start bit may be sampled on the edge immediately after the stop bit.
- dout_ready is ignored when dout_valid=0. dout never changes while dout_valid=1 except on a same-edge consume+load.

## Test plan
- Reset, then frame 0,1,0,1,0,0,1,0,1,0,1 with din_valid=1, dout_ready=0 -> dout=8'hA5, dout_valid=1 after 11th edge. No pulses.
- Same frame with din_valid toggling 1/0 every cycle -> identical result after 21 cycles. State holds on din_valid=0 edges.
- 8'hA5 frame with parity bit 1 -> parity_err one cycle, dout_valid stays 0. Next good 8'h3C frame (parity 0) -> dout=8'h3C.
- 8'hA5 frame with stop=0, then din=0 for 3 edges, then 1, then a good 8'h01 frame (parity 1) -> frame_err once, no false start. Only dout=8'h01 delivered.
- Two back-to-back good frames 8'h11, 8'h22 with dout_ready=0 -> dout stays 8'h11, overflow pulses at second stop. Repeat with dout_ready=1 at second stop edge -> dout=8'h22, dout_valid continuously 1, no overflow.
- reset=0 asserted mid-DATA for 2 cycles, then a good 8'hF0 frame -> all outputs 0 during reset, then dout=8'hF0 with no errors.

Source files
------------

// File: rtl/serial_deframer.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, even parity, stop bit.
// Good words go to a one-deep valid/ready buffer. Error and overflow pulses last one cycle.
module serial_deframer #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              din,
   input  logic              din_valid,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overflow
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_shift;
   logic              r_par;

   logic w_par_ok;
   logic w_good;

   // Even parity: the XOR over the data bits and the parity bit must be 0.
   assign w_par_ok = ((^r_shift) ^ r_par) == 1'b0;
   assign w_good   = din_valid && (r_state == S_STOP) && din && w_par_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;

         if (din_valid) begin
            case (r_state)
               S_IDLE: begin
                  if (!din) begin
                     r_state <= S_DATA;
                     r_cnt   <= '0;
                  end
               end
               S_DATA: begin
                  r_shift[r_cnt] <= din;
                  if (r_cnt == LAST_BIT) begin
                     r_state <= S_PARITY;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_PARITY: begin
                  r_par   <= din;
                  r_state <= S_STOP;
               end
               S_STOP: begin
                  // A bad stop bit masks any parity problem in the same frame.
                  if (!din) begin
                     frame_err <= 1'b1;
                     r_state   <= S_WAIT_IDLE;
                  end else begin
                     parity_err <= !w_par_ok;
                     r_state    <= S_IDLE;
                  end
               end
               S_WAIT_IDLE: begin
                  if (din) begin
                     r_state <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end

         // The output handshake runs every edge, sampled or not.
         if (w_good) begin
            if (!dout_valid || dout_ready) begin
               dout       <= r_shift;
               dout_valid <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_deframer.sv
// Bench for serial_deframer: a table of vectors, hand-written corner sequences, and
// randomized frames compared against a queue-based frame model.
module tb_serial_deframer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         din;
   logic         din_valid;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         parity_err;
   logic         frame_err;
   logic         overflow;

   int n_cmp = 0;
   int n_bad = 0;

   serial_deframer #(.DATA_W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: collects sampled bits of the current frame in a queue and
   // judges the whole frame once DATA_W+3 bits have arrived.
   bit           q[$];
   bit           m_wait;
   logic [W-1:0] m_dout;
   bit           m_valid, m_pe, m_fe, m_ov;

   function automatic void model_reset();
      q.delete();
      m_wait  = 1'b0;
      m_dout  = '0;
      m_valid = 1'b0;
      m_pe    = 1'b0;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
   endfunction

   function automatic void model_edge(input bit d, input bit dv, input bit rdy);
      bit           load = 1'b0;
      logic [W-1:0] word = '0;
      bit           chk_par;
      m_pe = 1'b0;
      m_fe = 1'b0;
      m_ov = 1'b0;
      if (dv) begin
         if (m_wait) begin
            if (d) m_wait = 1'b0;
         end else if (q.size() == 0) begin
            if (!d) q.push_back(1'b0);
         end else begin
            q.push_back(d);
            if (q.size() == W + 3) begin
               for (int i = 0; i < W; i++) word[i] = q[1 + i];
               chk_par = (^word) ^ q[W + 1];
               if (!q[W + 2]) begin
                  m_fe   = 1'b1;
                  m_wait = 1'b1;
               end else if (chk_par) begin
                  m_pe = 1'b1;
               end else begin
                  load = 1'b1;
               end
               q.delete();
            end
         end
      end
      if (load) begin
         if (!m_valid || rdy) begin
            m_dout  = word;
            m_valid = 1'b1;
         end else begin
            m_ov = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_zero();
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_pulses", {29'd0, parity_err, frame_err, overflow}, 32'd0);
   endtask

   // One clock: drive inputs, advance the model on the edge, compare #1 later.
   task automatic step(input logic d, input logic dv, input logic rdy);
      din        = d;
      din_valid  = dv;
      dout_ready = rdy;
      @(posedge clk);
      model_edge(d, dv, rdy);
      #1;
      chk("m_dout", 32'(dout), 32'(m_dout));
      chk("m_valid", 32'(dout_valid), 32'(m_valid));
      chk("m_perr", 32'(parity_err), 32'(m_pe));
      chk("m_ferr", 32'(frame_err), 32'(m_fe));
      chk("m_ovf", 32'(overflow), 32'(m_ov));
   endtask

   task automatic send_frame(input logic [W-1:0] w, input logic par_flip, input logic stop,
                             input logic rdy, input logic rdy_stop, input logic toggle);
      logic [W+2:0] b;
      b[0]     = 1'b0;
      b[W:1]   = w;
      b[W+1]   = (^w) ^ par_flip;
      b[W+2]   = stop;
      for (int i = 0; i < W + 3; i++) begin
         if (toggle && i > 0) step(~b[i], 1'b0, rdy);
         step(b[i], 1'b1, (i == W + 2) ? rdy_stop : rdy);
      end
   endtask

   typedef struct {
      logic         d;
      logic         dv;
      logic         rdy;
      logic [W-1:0] e_dout;
      logic         e_valid;
      logic         e_pe;
      logic         e_fe;
      logic         e_ov;
   } vec_t;

   vec_t tbl[11];

   initial begin
      logic [10:0]  fr;
      logic [W-1:0] w;
      logic         pf, st;
      int unsigned  gap;

      fr = {1'b1, 1'b0, 8'hA5, 1'b0};
      for (int i = 0; i < 11; i++) begin
         tbl[i] = '{d: fr[i], dv: 1'b1, rdy: 1'b0,
                    e_dout: (i == 10) ? 8'hA5 : 8'h00, e_valid: (i == 10),
                    e_pe: 1'b0, e_fe: 1'b0, e_ov: 1'b0};
      end

      reset      = 1'b0;
      din        = 1'b1;
      din_valid  = 1'b0;
      dout_ready = 1'b0;
      model_reset();
      #12;
      check_zero();
      @(posedge clk);
      #1 reset = 1'b1;

      // Plain 8'hA5 frame from the vector table
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].d, tbl[i].dv, tbl[i].rdy);
         chk("tbl_dout", 32'(dout), 32'(tbl[i].e_dout));
         chk("tbl_valid", 32'(dout_valid), 32'(tbl[i].e_valid));
         chk("tbl_pulses", {29'd0, parity_err, frame_err, overflow},
             {29'd0, tbl[i].e_pe, tbl[i].e_fe, tbl[i].e_ov});
      end
      step(1'b1, 1'b1, 1'b1);
      chk("consume_valid", 32'(dout_valid), 32'd0);
      chk("consume_dout_kept", 32'(dout), 32'h A5);

      // Same frame with din_valid toggling; unsampled bits driven inverted
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("toggle_dout", 32'(dout), 32'hA5);
      chk("toggle_valid", 32'(dout_valid), 32'd1);
      step(1'b1, 1'b1, 1'b1);

      // Bad parity, then a good 8'h3C
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("perr_pulse", 32'(parity_err), 32'd1);
      chk("perr_valid", 32'(dout_valid), 32'd0);
      step(1'b1, 1'b1, 1'b0);
      chk("perr_one_cycle", 32'(parity_err), 32'd0);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("after_perr_dout", 32'(dout), 32'h3C);
      chk("after_perr_valid", 32'(dout_valid), 32'd1);
      step(1'b1, 1'b1, 1'b1);

      // Bad stop (with bad parity too), trailing zeros, then a good 8'h01
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ferr_pulse", 32'(frame_err), 32'd1);
      chk("ferr_precedence", 32'(parity_err), 32'd0);
      repeat (3) step(1'b0, 1'b1, 1'b0);
      chk("ferr_no_false_start", 32'(dout_valid), 32'd0);
      step(1'b1, 1'b1, 1'b0);
      send_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("after_ferr_dout", 32'(dout), 32'h01);
      chk("after_ferr_valid", 32'(dout_valid), 32'd1);
      step(1'b1, 1'b1, 1'b1);

      // Back-to-back frames into a full buffer
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("ovf_pulse", 32'(overflow), 32'd1);
      chk("ovf_dout_kept", 32'(dout), 32'h11);
      step(1'b1, 1'b1, 1'b1);
      chk("ovf_one_cycle", 32'(overflow), 32'd0);

      // Same pair with a same-edge consume+load at the second stop
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("pair_first", 32'(dout), 32'h11);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("pair_second", 32'(dout), 32'h22);
      chk("pair_valid", 32'(dout_valid), 32'd1);
      chk("pair_no_ovf", 32'(overflow), 32'd0);

      // Reset in the middle of the data bits
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      reset = 1'b0;
      #1 check_zero();
      repeat (2) begin
         @(posedge clk);
         #1 check_zero();
      end
      reset = 1'b1;
      model_reset();
      step(1'b1, 1'b1, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_rst_dout", 32'(dout), 32'hF0);
      chk("post_rst_valid", 32'(dout_valid), 32'd1);
      chk("post_rst_errs", {30'd0, parity_err, frame_err}, 32'd0);

      // Randomized frames, errors, stalls and back-pressure against the model
      for (int k = 0; k < 400; k++) begin
         logic [W+2:0] b;
         gap = $urandom_range(0, 2);
         repeat (gap) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         w  = W'($urandom);
         pf = ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 7) != 0);
         b[0]   = 1'b0;
         b[W:1] = w;
         b[W+1] = (^w) ^ pf;
         b[W+2] = st;
         for (int i = 0; i < W + 3; i++) begin
            while ($urandom_range(0, 3) == 0)
               step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
            step(b[i], 1'b1, 1'($urandom_range(0, 1)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
